// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence detector.
package seq_det_pkg;

    // Reference pattern of the classic fixed detector; MSB is received first.
    localparam logic [4:0] PAT_11011 = 5'b11011;

    // Detection mode as driven on the overlap input.
    typedef enum logic {
        MODE_NOOVL = 1'b0,
        MODE_OVL   = 1'b1
    } ovl_mode_e;

    // Width of the fill counter; it must hold 0..len-1 and never collapse below one bit.
    function automatic int unsigned fill_width(input int unsigned len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit-stream, configuration and status bundle of the sequence detector.
import seq_det_pkg::*;

interface seq_detector_param_if #(
    parameter int unsigned LEN   = 5,
    parameter int unsigned CNT_W = 8
) ();
    localparam int unsigned FILL_W = fill_width(LEN);

    logic              in;
    logic              in_valid;
    logic              overlap;
    logic              cfg_load;
    logic [LEN-1:0]    cfg_pattern;
    logic              match;
    logic [CNT_W-1:0]  match_count;
    logic [FILL_W-1:0] fill;

    modport master (
        output in, in_valid, overlap, cfg_load, cfg_pattern,
        input  match, match_count, fill
    );

    modport slave (
        input  in, in_valid, overlap, cfg_load, cfg_pattern,
        output match, match_count, fill
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned     W   = 8,
    parameter logic [W-1:0]    MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, else step unless already at the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector with overlap control and match counter.
// Optional macro SEQDET_REG_OUT_EN registers the match pulse (one cycle later).
import seq_det_pkg::*;

module seq_detector_param #(
    parameter int unsigned    LEN             = 5,
    parameter logic [LEN-1:0] DEFAULT_PATTERN = LEN'(PAT_11011),
    parameter int unsigned    CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int unsigned FILL_W = fill_width(LEN);
    localparam int unsigned HIST_W = LEN - 1;

    logic [LEN-1:0]    pattern_q, pattern_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  count;
    logic              consume_c;
    logic              match_c;
    logic              fill_clr_c;
    ovl_mode_e         mode_c;

    // A bit is consumed only when valid and not overridden by reset or reload.
    assign consume_c  = bus.in_valid & ~rst & ~bus.cfg_load;
    assign match_c    = consume_c & (fill == FILL_W'(LEN - 1)) & ({hist_q, bus.in} == pattern_q);
    assign mode_c     = ovl_mode_e'(bus.overlap);
    // Non-overlapping mode discards history after a hit; a reload always does.
    assign fill_clr_c = bus.cfg_load | (match_c & (mode_c == MODE_NOOVL));

    // Pattern/history next state; history content is irrelevant while fill is short.
    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            hist_d    = '0;
        end else if (bus.in_valid) begin
            hist_d = HIST_W'({hist_q, bus.in});
        end
    end

    // Pattern and history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEFAULT_PATTERN;
            hist_q    <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
        end
    end

    sat_counter #(
        .W   (FILL_W),
        .MAX (FILL_W'(LEN - 1))
    ) u_fill (
        .clk   (clk),
        .rst   (rst),
        .clr_i (fill_clr_c),
        .inc_i (consume_c),
        .cnt_o (fill)
    );

    sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_match_count (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.cfg_load),
        .inc_i (match_c),
        .cnt_o (count)
    );

`ifdef SEQDET_REG_OUT_EN
    logic match_r_q;

    // Registered match: one-cycle delayed copy of the combinational hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_r_q <= 1'b0;
        end else begin
            match_r_q <= match_c;
        end
    end

    assign bus.match = match_r_q;
`else
    assign bus.match = match_c;
`endif

    assign bus.match_count = count;
    assign bus.fill        = fill;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, hand sequences and random traffic vs a queue model.
`timescale 1ns/1ps
import seq_det_pkg::*;

module tb_seq_detector_param;
    localparam int unsigned LEN     = 5;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = 255;
    localparam logic [4:0]  D5      = 5'b11011;
    localparam logic [4:0]  A5      = 5'b10101;
    localparam logic [4:0]  ONES5   = 5'b11111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detector_param_if #(.LEN(LEN), .CNT_W(CNT_W)) bus_if ();

    seq_detector_param #(.LEN(LEN), .DEFAULT_PATTERN(D5), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: queue of consumed bits since last clear (newest at back).
    bit         mq[$];
    logic [4:0] mpat = D5;
    int         mcnt = 0;
    logic       mreg = 1'b0;

    typedef struct {
        logic       r, d, v, o, l;
        logic [4:0] p;
        logic       em;
        int         ec;
        int         ef;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic model_match(input logic r, input logic d, input logic v, input logic l);
        int unsigned w;
        if (!v || r || l || (mq.size() != LEN - 1)) return 1'b0;
        w = 0;
        foreach (mq[i]) w = (w << 1) | int'(mq[i]);
        w = (w << 1) | int'(d);
        return (5'(w) == mpat);
    endfunction

    // One cycle: drive at negedge, sample 1ns later, check against model, advance model.
    task automatic step(input logic r, input logic d, input logic v, input logic o,
                        input logic l, input logic [4:0] p,
                        output logic am, output logic [CNT_W-1:0] ac, output logic [2:0] af);
        logic em;
        @(negedge clk);
        rst                = r;
        bus_if.in          = d;
        bus_if.in_valid    = v;
        bus_if.overlap     = o;
        bus_if.cfg_load    = l;
        bus_if.cfg_pattern = p;
        #1;
        am = bus_if.match;
        ac = bus_if.match_count;
        af = bus_if.fill;
        em = model_match(r, d, v, l);
`ifdef SEQDET_REG_OUT_EN
        chk("model_match", 32'(am), 32'(mreg));
`else
        chk("model_match", 32'(am), 32'(em));
`endif
        chk("model_count", 32'(ac), 32'(mcnt));
        chk("model_fill", 32'(af), 32'(mq.size()));
        mreg = r ? 1'b0 : em;
        if (r) begin
            mq.delete();
            mpat = D5;
            mcnt = 0;
        end else if (l) begin
            mq.delete();
            mpat = p;
            mcnt = 0;
        end else if (v) begin
            if (em && !o) begin
                mq.delete();
            end else begin
                mq.push_back(d);
                if (mq.size() > LEN - 1) void'(mq.pop_front());
            end
            if (em && (mcnt < CNT_MAX)) mcnt++;
        end
    endtask

    function automatic void add(input logic r, input logic d, input logic v, input logic o,
                                input logic l, input logic [4:0] p,
                                input logic em, input int ec, input int ef);
        vec_t t;
        t.r = r; t.d = d; t.v = v; t.o = o; t.l = l; t.p = p;
        t.em = em; t.ec = ec; t.ef = ef;
        tbl.push_back(t);
    endfunction

    initial begin
        logic             am;
        logic [CNT_W-1:0] ac;
        logic [2:0]       af;
        logic             tprev;

        rst                = 1'b1;
        bus_if.in          = 1'b1;
        bus_if.in_valid    = 1'b1;
        bus_if.overlap     = 1'b1;
        bus_if.cfg_load    = 1'b0;
        bus_if.cfg_pattern = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_match", 32'(bus_if.match), 32'd0);
        chk("reset_count", 32'(bus_if.match_count), 32'd0);
        chk("reset_fill", 32'(bus_if.fill), 32'd0);

        // r d v o l pat  em count fill (count/fill observed before the edge)
        // Default pattern, overlapping: hits on bits 5 and 8.
        add(0,1,1,1,0,D5, 0,0,0); add(0,1,1,1,0,D5, 0,0,1); add(0,0,1,1,0,D5, 0,0,2);
        add(0,1,1,1,0,D5, 0,0,3); add(0,1,1,1,0,D5, 1,0,4); add(0,0,1,1,0,D5, 0,1,4);
        add(0,1,1,1,0,D5, 0,1,4); add(0,1,1,1,0,D5, 1,1,4); add(0,0,0,1,0,D5, 0,2,4);
        add(1,1,1,1,0,D5, 0,2,4);
        // Same stream non-overlapping: one hit, fill restarts.
        add(0,1,1,0,0,D5, 0,0,0); add(0,1,1,0,0,D5, 0,0,1); add(0,0,1,0,0,D5, 0,0,2);
        add(0,1,1,0,0,D5, 0,0,3); add(0,1,1,0,0,D5, 1,0,4); add(0,0,1,0,0,D5, 0,1,0);
        add(0,1,1,0,0,D5, 0,1,1); add(0,1,1,0,0,D5, 0,1,2); add(0,0,0,0,0,D5, 0,1,3);
        add(1,0,0,0,0,D5, 0,1,3);
        // 1101111011 non-overlapping: hits on bits 5 and 10.
        add(0,1,1,0,0,D5, 0,0,0); add(0,1,1,0,0,D5, 0,0,1); add(0,0,1,0,0,D5, 0,0,2);
        add(0,1,1,0,0,D5, 0,0,3); add(0,1,1,0,0,D5, 1,0,4); add(0,1,1,0,0,D5, 0,1,0);
        add(0,1,1,0,0,D5, 0,1,1); add(0,0,1,0,0,D5, 0,1,2); add(0,1,1,0,0,D5, 0,1,3);
        add(0,1,1,0,0,D5, 1,1,4); add(0,0,0,0,0,D5, 0,2,0);
        // Load 10101 (bit in same cycle discarded), overlapping 1010101: hits on 5 and 7.
        add(0,1,1,1,1,A5, 0,2,0);
        add(0,1,1,1,0,D5, 0,0,0); add(0,0,1,1,0,D5, 0,0,1); add(0,1,1,1,0,D5, 0,0,2);
        add(0,0,1,1,0,D5, 0,0,3); add(0,1,1,1,0,D5, 1,0,4); add(0,0,1,1,0,D5, 0,1,4);
        add(0,1,1,1,0,D5, 1,1,4); add(0,0,0,1,0,D5, 0,2,4);
        // Reload 11011, then send it spread over gaps with in=1 on gap cycles.
        add(0,0,0,1,1,D5, 0,2,4);
        add(0,1,1,1,0,D5, 0,0,0); add(0,1,0,1,0,D5, 0,0,1); add(0,1,1,1,0,D5, 0,0,1);
        add(0,1,0,1,0,D5, 0,0,2); add(0,0,1,1,0,D5, 0,0,2); add(0,1,0,1,0,D5, 0,0,3);
        add(0,1,1,1,0,D5, 0,0,3); add(0,1,0,1,0,D5, 0,0,4); add(0,1,1,1,0,D5, 1,0,4);
        add(0,0,0,1,0,D5, 0,1,4);
        // Reset after 3 bits, then full sequence: single hit on 5th post-reset bit.
        add(1,0,0,1,0,D5, 0,1,4);
        add(0,1,1,1,0,D5, 0,0,0); add(0,1,1,1,0,D5, 0,0,1); add(0,0,1,1,0,D5, 0,0,2);
        add(1,1,1,1,0,D5, 0,0,3);
        add(0,1,1,1,0,D5, 0,0,0); add(0,1,1,1,0,D5, 0,0,1); add(0,0,1,1,0,D5, 0,0,2);
        add(0,1,1,1,0,D5, 0,0,3); add(0,1,1,1,0,D5, 1,0,4); add(0,0,0,1,0,D5, 0,1,4);
        // Reset beats a simultaneous load: default pattern still active afterwards.
        add(1,0,0,1,1,A5, 0,1,4);
        add(0,1,1,1,0,D5, 0,0,0); add(0,1,1,1,0,D5, 0,0,1); add(0,0,1,1,0,D5, 0,0,2);
        add(0,1,1,1,0,D5, 0,0,3); add(0,1,1,1,0,D5, 1,0,4); add(0,0,0,1,0,D5, 0,1,4);

        tprev = 1'b0;
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].d, tbl[i].v, tbl[i].o, tbl[i].l, tbl[i].p, am, ac, af);
`ifdef SEQDET_REG_OUT_EN
            chk($sformatf("tbl%0d_match", i), 32'(am), 32'(tprev));
`else
            chk($sformatf("tbl%0d_match", i), 32'(am), 32'(tbl[i].em));
`endif
            chk($sformatf("tbl%0d_count", i), 32'(ac), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_fill", i), 32'(af), 32'(tbl[i].ef));
            tprev = tbl[i].r ? 1'b0 : tbl[i].em;
        end

        // All-ones pattern, overlapping: hit on every bit once full; counter saturates.
        step(0, 0, 0, 1, 1, ONES5, am, ac, af);
        for (int i = 0; i < 300; i++) step(0, 1, 1, 1, 0, D5, am, ac, af);
        step(0, 1, 1, 1, 0, D5, am, ac, af);
        chk("sat_count", 32'(ac), 32'(CNT_MAX));
        chk("sat_fill", 32'(af), 32'(LEN - 1));
        chk("sat_match", 32'(am), 32'd1);

        // Random traffic; half the time the data bit follows the loaded pattern to raise hit rate.
        for (int i = 0; i < 3000; i++) begin
            logic r, d, v, o, l;
            logic [4:0] p;
            int unsigned k;
            r = 1'($urandom_range(0, 149) == 0);
            l = 1'($urandom_range(0, 59) == 0);
            v = 1'($urandom_range(0, 3) != 0);
            o = 1'($urandom_range(0, 1));
            p = 5'($urandom_range(0, 31));
            k = $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1) d = mpat[4 - k];
            else d = 1'($urandom_range(0, 1));
            step(r, d, v, o, l, p, am, ac, af);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
